// File: rtl/shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter
//   Round-robin owner selection for one W-bit tri-state bus shared by N
//   requesters. Only one requester owns the bus at a time. Every change of
//   owner passes through a one-cycle turnaround with nobody driving, so the
//   resolved net never sees two drivers. An owner that keeps its request up
//   for MAX_HOLD cycles is released and flagged with timeout_err.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req[N]       level request, bit i = requester i
//   data_in[N*W] requester data, slice [i*W +: W] = requester i
//   grant[N]     registered one-hot (or zero) grant
//   bus[W]       shared net: owner data at strong strength, z otherwise
//   bus_valid    high while bus is driven (grant != 0)
//   timeout_err  one-cycle pulse in the turnaround after a forced release
//   owner        index of the current owner, 0 while nobody owns the bus
// ---------------------------------------------------------------------------
module shared_bus_arbiter #(
  parameter  int N        = 4,
  parameter  int W        = 8,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data_in,
  output logic [N-1:0]    grant,
  output tri   [W-1:0]    bus,
  output logic            bus_valid,
  output logic            timeout_err,
  output logic [IW-1:0]   owner
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q,   ptr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            tmo_q,   tmo_d;

  // ---------------------------------------------------------------------
  // Round-robin search: first set request starting at ptr, wrapping.
  // ---------------------------------------------------------------------
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   nxt_ptr;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Winner becomes lowest priority for the following arbitration.
  assign nxt_ptr = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      // IDLE and TURN arbitrate identically; TURN only exists to force the
      // undriven cycle between two owners.
      IDLE, TURN: begin
        grant_d = '0;
        owner_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
        if (win_vld) begin
          state_d          = OWN;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          ptr_d            = nxt_ptr;
          cnt_d            = CW'(1);
        end
      end
      OWN: begin
        if (!req[owner_q] || cnt_q == CW'(MAX_HOLD)) begin
          state_d = TURN;
          grant_d = '0;
          owner_d = '0;
          cnt_d   = '0;
          // A voluntary release is never an error, even at the hold limit.
          tmo_d   = req[owner_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------
  // Data path: owner data straight through to the shared net.
  // ---------------------------------------------------------------------
  logic [N-1:0][W-1:0] din_a;
  assign din_a = data_in;

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign bus_valid   = |grant_q;
  assign timeout_err = tmo_q;

  assign (strong1, strong0) bus = bus_valid ? din_a[owner_q] : {W{1'bz}};

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_bus_arbiter
//   Directed scenarios followed by a random phase. A reference model tracks
//   who owns the bus, for how long, and the next-priority requester, and
//   predicts grant / owner / bus / bus_valid / timeout_err each cycle.
// ---------------------------------------------------------------------------
module tb_shared_bus_arbiter;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 8;
  localparam int IW       = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    grant;
  wire  [W-1:0]    bus;
  logic            bus_valid;
  logic            timeout_err;
  logic [IW-1:0]   owner;

  shared_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .bus         (bus),
    .bus_valid   (bus_valid),
    .timeout_err (timeout_err),
    .owner       (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = nobody), cycles held, next priority.
  int m_own  = -1;
  int m_held = 0;
  int m_ptr  = 0;
  bit m_tmo  = 1'b0;

  // Optional fixed data for one requester.
  int             pin_idx = -1;
  logic [W-1:0]   pin_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_tmo = 1'b0;
    if (rst) begin
      m_own  = -1;
      m_held = 0;
      m_ptr  = 0;
    end else if (m_own >= 0) begin
      if (!req[m_own] || m_held == MAX_HOLD) begin
        m_tmo  = req[m_own];
        m_own  = -1;
        m_held = 0;
      end else begin
        m_held++;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (req[c]) begin
          m_own  = c;
          m_held = 1;
          m_ptr  = (c + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("grant",       32'(grant),            32'(eg));
    chk("bus_valid",   32'(bus_valid),        32'(m_own >= 0));
    chk("timeout_err", 32'(timeout_err),      32'(m_tmo));
    chk("owner",       32'(owner),            (m_own >= 0) ? 32'(m_own) : 32'd0);
    chk("onehot0",     32'($onehot0(grant)),  32'd1);
    if (m_own >= 0)
      chk("bus",       32'(bus),              32'(data_in[m_own*W +: W]));
  endtask

  task automatic step(input logic r, input logic [N-1:0] q);
    rst = r;
    req = q;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = W'($urandom);
    if (pin_idx >= 0) data_in[pin_idx*W +: W] = pin_val;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [N-1:0] prev_g;
    logic [N-1:0] q;
    logic [N-1:0] order[$];
    int           tmo_cnt;
    int           g_cnt;

    rst     = 1'b1;
    req     = '0;
    data_in = '0;

    // Reset held with every requester asking.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_tmo",   32'(timeout_err), 32'd0);
    step(1'b0, 4'b1111);
    chk("post_rst_grant", 32'(grant), 32'b0001);

    // Single requester with fixed data.
    step(1'b1, 4'b0000);
    pin_idx = 2;
    pin_val = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0100);
      chk("single_grant", 32'(grant), 32'b0100);
      chk("single_bus",   32'(bus),   32'h00A5);
    end
    step(1'b0, 4'b0000);
    chk("single_turn", 32'(bus_valid), 32'd0);
    step(1'b0, 4'b0000);
    chk("single_idle", 32'(bus_valid), 32'd0);
    pin_idx = -1;

    // Round robin: everyone requests, each owner lets go after 2 cycles.
    step(1'b1, 4'b0000);
    prev_g = '0;
    for (int i = 0; i < 18; i++) begin
      q = '1;
      if (m_own >= 0 && m_held == 2) q[m_own] = 1'b0;
      step(1'b0, q);
      if (grant != 0 && prev_g == 0) order.push_back(grant);
      prev_g = grant;
    end
    chk("rr_count", 32'(order.size() >= 5), 32'd1);
    if (order.size() >= 5) begin
      chk("rr_0", 32'(order[0]), 32'b0001);
      chk("rr_1", 32'(order[1]), 32'b0010);
      chk("rr_2", 32'(order[2]), 32'b0100);
      chk("rr_3", 32'(order[3]), 32'b1000);
      chk("rr_4", 32'(order[4]), 32'b0001);
    end

    // Timeout: requester 1 never lets go.
    step(1'b1, 4'b0000);
    tmo_cnt = 0;
    g_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0010);
      if (timeout_err) tmo_cnt++;
      if (grant == 4'b0010) g_cnt++;
    end
    chk("tmo_pulses", 32'(tmo_cnt), 32'd2);
    chk("tmo_grants", 32'(g_cnt),   32'd18);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Voluntary release exactly at the hold limit: no error.
    step(1'b1, 4'b0000);
    for (int i = 0; i < MAX_HOLD; i++) step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    chk("limit_release_grant", 32'(grant),       32'd0);
    chk("limit_release_tmo",   32'(timeout_err), 32'd0);

    // Handover fairness: 0 owns, 3 waits, 0 re-asks during turnaround.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b1001);
    chk("ho_hold0", 32'(grant), 32'b0001);
    step(1'b0, 4'b1000);
    chk("ho_turn", 32'(grant), 32'd0);
    step(1'b0, 4'b1001);
    chk("ho_to3", 32'(grant), 32'b1000);
    step(1'b0, 4'b1001);
    chk("ho_keep3", 32'(grant), 32'b1000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    chk("ho_back0", 32'(grant), 32'b0001);

    // Reset in the third cycle of an ownership.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010);
    step(1'b1, 4'b0010);
    chk("mid_rst_grant", 32'(grant),       32'd0);
    chk("mid_rst_tmo",   32'(timeout_err), 32'd0);
    step(1'b0, 4'b0011);
    chk("mid_rst_next",  32'(grant),       32'b0001);

    // Random traffic.
    q = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) q[$urandom_range(0, N-1)] ^= 1'b1;
      step(($urandom_range(0, 59) == 0), q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
